// File: rtl/clk_period_monitor.sv
// Measures the divided slow-clock period in clk cycles, checks it against a
// tolerance window and flags a stalled clock after TIMEOUT cycles without an edge.
module clk_period_monitor #(
   parameter int unsigned EXP_PERIOD = 50000,
   parameter int unsigned TOL        = 500,
   parameter int unsigned TIMEOUT    = 100000,
   parameter int unsigned CNT_W      = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             slow_clk,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             in_range,
   output logic             lost
);

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   // Window bounds held one bit wider than 32 so neither bound can wrap.
   localparam logic [32:0] LO_B = (EXP_PERIOD >= TOL) ? 33'(EXP_PERIOD - TOL) : 33'd0;
   localparam logic [32:0] HI_B = 33'(EXP_PERIOD) + 33'(TOL);

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t           state_q, state_d;
   logic             sync1, sync2, prev;
   logic [CNT_W-1:0] cnt;
   logic             rise, cnt_ok;
   logic [CNT_W-1:0] period_d;
   logic             pv_d, inr_d, lost_d;

   assign rise   = sync2 & ~prev;
   assign cnt_ok = (33'(cnt) >= LO_B) && (33'(cnt) <= HI_B);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= slow_clk;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   // Free-running interval counter; saturation at TMO doubles as the stall detector.
   always_ff @(posedge clk) begin
      if (rst)              cnt <= '0;
      else if (rise)        cnt <= CNT_W'(1);
      else if (cnt != TMO)  cnt <= cnt + CNT_W'(1);
   end

   always_comb begin
      state_d  = state_q;
      period_d = period;
      pv_d     = 1'b0;
      inr_d    = in_range;
      lost_d   = lost;
      if (rise) begin
         // The first edge after IDLE only starts timing.
         state_d = MEASURE;
         if (state_q == MEASURE) begin
            period_d = cnt;
            pv_d     = 1'b1;
            inr_d    = cnt_ok;
            lost_d   = 1'b0;
         end
      end else if (cnt == TMO) begin
         state_d = IDLE;
         lost_d  = 1'b1;
         inr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         period       <= '0;
         period_valid <= 1'b0;
         in_range     <= 1'b0;
         lost         <= 1'b0;
      end else begin
         state_q      <= state_d;
         period       <= period_d;
         period_valid <= pv_d;
         in_range     <= inr_d;
         lost         <= lost_d;
      end
   end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Scoreboard bench for clk_period_monitor, run with a scaled-down period and
// timeout so every scenario fits in a short simulation.
module tb_clk_period_monitor;

   localparam int EXP  = 50;
   localparam int TOL  = 5;
   localparam int TMO  = 100;
   localparam int CW   = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          slow_clk;
   logic [CW-1:0] period;
   logic          period_valid, in_range, lost;

   typedef struct {int p; int ir;} exp_t;
   exp_t sb[$];

   int n_chk = 0, n_fail = 0;
   int cyc = 0, last_pulse_cyc = 0, r_cyc = 0;
   int last_p = -1;
   bit pv_prev = 1'b0;

   clk_period_monitor #(.EXP_PERIOD(EXP), .TOL(TOL), .TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .slow_clk(slow_clk), .period(period),
      .period_valid(period_valid), .in_range(in_range), .lost(lost)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic void chk(string name, int act, int expv);
      n_chk++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endfunction

   // Monitor: every period_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (period_valid) begin
         chk("pulse_width", int'(pv_prev), 0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse_period", int'(period), -1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("period", int'(period), e.p);
            chk("in_range", int'(in_range), e.ir);
            chk("lost_clr", int'(lost), 0);
         end
         last_pulse_cyc = cyc;
      end
      pv_prev = period_valid;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One slow-clock cycle of length p starting with a rising edge; that edge
   // reports the previous cycle's length when the monitor is armed.
   task automatic gen_period(input int p, input int exp_ir);
      if (last_p > 0) sb.push_back('{last_p, exp_ir});
      slow_clk = 1'b1;
      wait_cyc(p / 2);
      slow_clk = 1'b0;
      wait_cyc(p - p / 2);
      last_p = p;
   endtask

   task automatic wait_lost();
      for (int i = 0; i < 3 * TMO && !lost; i++) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      slow_clk = 1'b0;
      // Reset and idle
      repeat (3) begin
         @(negedge clk);
         chk("rst_period", int'(period), 0);
         chk("rst_pv", int'(period_valid), 0);
         chk("rst_in_range", int'(in_range), 0);
         chk("rst_lost", int'(lost), 0);
      end
      rst = 1'b0;
      r_cyc = cyc;
      wait_lost();
      chk("idle_lost", int'(lost), 1);
      chk("idle_lost_delay", cyc - r_cyc, TMO + 1);

      // Nominal: first edge silent, later edges report 50 in range
      gen_period(50, 1);
      chk("first_edge_keeps_lost", int'(lost), 1);
      gen_period(50, 1);
      gen_period(50, 1);
      gen_period(50, 1);

      // Stall and recovery
      last_p = -1;
      wait_lost();
      chk("stall_lost", int'(lost), 1);
      chk("stall_delay", cyc - last_pulse_cyc, TMO);
      chk("stall_in_range", int'(in_range), 0);
      chk("stall_period_held", int'(period), 50);
      gen_period(50, 1);
      chk("rearm_lost", int'(lost), 1);
      gen_period(55, 1);   // reports 50

      // Tolerance boundaries
      gen_period(45, 1);   // reports 55
      gen_period(56, 1);   // reports 45
      gen_period(44, 0);   // reports 56
      // Priority: interval exactly TMO
      gen_period(100, 0);  // reports 44
      gen_period(50, 0);   // reports 100, rise beats timeout
      chk("prio_lost", int'(lost), 0);

      // Reset mid-measurement
      gen_period(50, 1);   // reports 50
      sb.push_back('{50, 1});
      slow_clk = 1'b1;
      wait_cyc(15);
      slow_clk = 1'b0;
      wait_cyc(5);
      chk("pre_rst_period", int'(period), 50);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_period", int'(period), 0);
      chk("mid_rst_in_range", int'(in_range), 0);
      chk("mid_rst_lost", int'(lost), 0);
      @(negedge clk);
      rst = 1'b0;
      last_p = -1;
      wait_cyc(10);
      gen_period(50, 1);   // first edge after reset: silent
      gen_period(47, 1);   // reports 50
      gen_period(50, 1);   // reports 47
      wait_cyc(10);
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
